pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised, multi-entry elastic stage register for the 5-stage core. Generalises the single-entry fs_ds / ds_ex / ex_mem / mem_wb registers.
- Upstream side: valid / allow_in handshake. Downstream side: valid / allow_in handshake.
- Adds configurable depth, optional ready pass-through, synchronous flush (branch kill) and a saturating back-pressure stall counter.
- Instantiated between any two stages. With DEPTH=1 and READY_PASS=1 it replaces the existing per-stage registers.

Parameters:
- DATA_W, 32, width of the stage payload bus (e.g. `FS_DATA, `ID_DATA).
- DEPTH, 2, number of buffer entries; legal range 1..8.
- READY_PASS, 1, 1: allow_in also asserts when full and the downstream pops this cycle; 0: allow_in depends only on occupancy.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  upstream holds a valid payload.
- in_data  in  DATA_W  upstream payload.
- allow_in  out  1  this buffer accepts a payload this cycle.
- out_valid  out  1  head entry is valid.
- out_data  out  DATA_W  head entry payload.
- out_allow_in  in  1  downstream accepts the head this cycle.
- flush  in  1  discard all entries (branch taken / redirect).
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_allow_in=0, saturating.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (reset=0, asynchronous):
  - read pointer, write pointer and occupancy = 0; stall_cnt = 0.
  - out_valid = 0; allow_in = 1 once reset releases; out_data = 0.
  - Entry storage is not reset.
- Storage: circular array of DEPTH entries. Head at rd_ptr, tail at wr_ptr.
  - Pointers wrap from DEPTH-1 to 0; non-power-of-two DEPTH must wrap correctly.
- Transfer conditions:
  - push = in_valid & allow_in & ~flush.
  - pop = out_valid & out_allow_in & ~flush.
- allow_in:
  - READY_PASS=0: allow_in = (occupancy < DEPTH).
  - READY_PASS=1: allow_in = (occupancy < DEPTH) | (out_valid & out_allow_in). This is the only combinational path from out_allow_in to allow_in.
- Outputs are combinational from state:
  - out_valid = (occupancy != 0).
  - out_data = entry[rd_ptr], which is 0 when empty.
- Latency: a payload pushed in cycle N is visible on out_data in cycle N+1 at the earliest. There is no combinational in-to-out bypass.
- Throughput: one push and one pop per cycle is sustained when DEPTH>=2, or when READY_PASS=1.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
  - Full with READY_PASS=1: the pop frees the slot written by the same-cycle push.
  - Empty: no pop is possible, so the push lands and out_valid rises next cycle.
- Flush (synchronous):
  - Next cycle: occupancy = 0 and rd_ptr = wr_ptr = 0.
  - The same-cycle push is dropped and the same-cycle pop does not occur.
  - allow_in during the flush cycle follows its normal equation, but nothing is written.
- Stall counter:
  - Increments by 1 when out_valid & ~out_allow_in & ~flush.
  - Holds at 2^CNT_W-1.
  - stall_clr has priority over increment: counter goes to 0 next cycle.
  - flush does not clear stall_cnt.
- Upstream protocol: in_data must stay stable while in_valid=1 and allow_in=0. The buffer does not check this.
- Reset mid-operation: all entries are lost immediately; out_valid falls asynchronously.

Decomposition:
- Shared package / pipeline.vh additions:
  - `PSB_MAX_DEPTH = 8.
  - Pointer-width helper macro.
  - Existing stage-data width macros, passed in as DATA_W.
- Natural sub-module: psb_sat_counter (CNT_W, inc, clr, saturating). It is reused by future performance counters.
- The storage array stays inline.

Test Plan:
- Reset, then DEPTH=2, READY_PASS=0, out_allow_in=0; push 0xA1, 0xB2, 0xC3 on consecutive cycles -> allow_in drops after 2 pushes; occupancy = 2; 0xC3 is held upstream; stall_cnt increments from the cycle after the first push.
- Full buffer, in_valid=1 and out_allow_in=1 for 10 cycles, READY_PASS=1, DEPTH=1 -> one transfer per cycle; data order preserved; occupancy stays 1.
- DEPTH=3, push 6 distinct words while popping every other cycle -> pointer wrap at 3; output order equals input order; occupancy never exceeds 3.
- flush asserted with occupancy=2 and a concurrent push of 0xDEAD -> next cycle out_valid = 0, occupancy = 0; 0xDEAD never appears on out_data.
- CNT_W=4, hold out_valid=1 with out_allow_in=0 for 20 cycles -> stall_cnt saturates at 15; pulse stall_clr with the stall still present -> stall_cnt = 0 next cycle, then resumes counting.
- Drive reset=0 asynchronously mid-stream between clock edges -> out_valid and occupancy go to 0 without waiting for a clock edge; after release, allow_in = 1.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants and helpers for the elastic pipeline stage buffer.
// Depth limits and the pointer-width helper live here so other stages can size against them.
package pipe_stage_buf_pkg;

    localparam int PSB_MAX_DEPTH = 8;

    // Pointer width for a circular buffer; a single entry still needs one bit.
    function automatic int psb_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; the count holds at all-ones.
module pipe_stage_buf_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Multi-entry elastic stage register with valid/allow_in handshakes on both sides,
// synchronous flush and a saturating back-pressure stall counter.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2,
    parameter int READY_PASS = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       allow_in,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_allow_in,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    input  logic                       stall_clr
);

    localparam int PTR_W = psb_ptr_w(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DATA_W-1:0] entry_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic full;
    logic pop_ready;
    logic push;
    logic pop;
    logic stall_inc;

    // Explicit wrap so non-power-of-two depths cycle through DEPTH slots only.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        full      = (occ_q == FULL_OCC);
        out_valid = (occ_q != '0);
        pop_ready = out_valid && out_allow_in;
        allow_in  = !full || ((READY_PASS != 0) && pop_ready);
        push      = in_valid && allow_in && !flush;
        pop       = pop_ready && !flush;
        stall_inc = out_valid && !out_allow_in && !flush;
        out_data  = out_valid ? entry_mem[rd_ptr_q] : '0;
        occupancy = occ_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (push && !pop) begin
                occ_d = occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload storage carries no reset; out_data is gated by occupancy instead.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr_q] <= in_data;
        end
    end

    pipe_stage_buf_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: three buffer configurations share one stimulus stream and are
// compared every cycle against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_allow_in;
    logic        flush;
    logic        stall_clr;

    logic        allow_w [NI];
    logic        ov_w    [NI];
    logic [31:0] data_w  [NI];
    logic [3:0]  occ_w   [NI];
    logic [15:0] cnt_w   [NI];

    int mdepth [NI] = '{2, 1, 3};
    int mrp    [NI] = '{0, 1, 1};
    int mcw    [NI] = '{4, 16, 4};

    logic [31:0] mq [NI][$];
    int          mcnt [NI];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        localparam int RP = (g == 0) ? 0 : 1;
        localparam int CW = (g == 1) ? 16 : 4;
        logic [$clog2(D+1)-1:0] occ_l;
        logic [CW-1:0]          cnt_l;
        logic                   allow_l;
        logic                   ov_l;
        logic [31:0]            data_l;

        pipe_stage_buf #(
            .DATA_W     (32),
            .DEPTH      (D),
            .READY_PASS (RP),
            .CNT_W      (CW)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid),
            .in_data      (in_data),
            .allow_in     (allow_l),
            .out_valid    (ov_l),
            .out_data     (data_l),
            .out_allow_in (out_allow_in),
            .flush        (flush),
            .occupancy    (occ_l),
            .stall_cnt    (cnt_l),
            .stall_clr    (stall_clr)
        );

        assign allow_w[g] = allow_l;
        assign ov_w[g]    = ov_l;
        assign data_w[g]  = data_l;
        assign occ_w[g]   = 4'(occ_l);
        assign cnt_w[g]   = 16'(cnt_l);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_allow(input int i);
        int occ;
        occ = mq[i].size();
        return (occ < mdepth[i]) || ((mrp[i] != 0) && (occ > 0) && out_allow_in);
    endfunction

    function automatic logic [53:0] exp_vec(input int i);
        int          occ;
        logic [31:0] head;
        occ  = mq[i].size();
        head = (occ > 0) ? mq[i][0] : 32'h0;
        return {model_allow(i), (occ > 0), head, 4'(occ), 16'(mcnt[i])};
    endfunction

    function automatic logic [53:0] obs_vec(input int i);
        return {allow_w[i], ov_w[i], data_w[i], occ_w[i], cnt_w[i]};
    endfunction

    // Reference model: applies one clock edge using the currently driven inputs.
    task automatic model_advance();
        for (int i = 0; i < NI; i++) begin
            logic ov;
            logic al;
            ov = (mq[i].size() > 0);
            al = model_allow(i);
            if (stall_clr) mcnt[i] = 0;
            else if (ov && !out_allow_in && !flush && mcnt[i] < (1 << mcw[i]) - 1) mcnt[i]++;
            if (flush) begin
                mq[i].delete();
            end else begin
                if (ov && out_allow_in) void'(mq[i].pop_front());
                if (in_valid && al) mq[i].push_back(in_data);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 0; in_data = 0; out_allow_in = 0; flush = 0; stall_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL reset inst %0d got %h expected %h", i, obs_vec(i), exp_vec(i));
            end
            checks++;
            if (allow_w[i] !== 1'b1 || ov_w[i] !== 1'b0 || data_w[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs inst %0d allow %b ov %b data %h expected 1 0 0",
                         i, allow_w[i], ov_w[i], data_w[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        out_allow_in = 0; flush = 0; stall_clr = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1;
            in_data  = (c == 0) ? 32'hA1 : (c == 1) ? 32'hB2 : 32'hC3;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL fill c%0d inst %0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
                end
            end
            if (c == 2) begin
                checks++;
                if (allow_w[0] !== 1'b0 || occ_w[0] !== 4'd2 || data_w[0] !== 32'hA1 || cnt_w[0] !== 16'd1) begin
                    errors++;
                    $display("FAIL fill_full allow %b occ %0d data %h cnt %0d expected 0 2 a1 1",
                             allow_w[0], occ_w[0], data_w[0], cnt_w[0]);
                end
            end
            model_advance();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pass_through();
        flush = 0; stall_clr = 0;
        for (int c = 0; c < 11; c++) begin
            in_valid     = 1;
            in_data      = $urandom;
            out_allow_in = (c != 0);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL pass c%0d inst %0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
                end
            end
            if (c != 0) begin
                checks++;
                if (occ_w[1] !== 4'd1 || allow_w[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL pass_depth1 c%0d occ %0d allow %b expected 1 1", c, occ_w[1], allow_w[1]);
                end
            end
            model_advance();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stall_clr = 0;
        for (int c = 0; c < 8; c++) begin
            flush        = (c == 0) || (c == 3);
            in_valid     = (c != 0);
            in_data      = (c == 1) ? 32'h11 : (c == 2) ? 32'h22 : 32'hDEAD;
            in_valid     = in_valid && (c < 4);
            out_allow_in = (c >= 4);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL flush c%0d inst %0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
                end
                if (c >= 4) begin
                    checks++;
                    if (ov_w[i] !== 1'b0 || occ_w[i] !== 4'd0 || data_w[i] === 32'hDEAD) begin
                        errors++;
                        $display("FAIL flush_empty c%0d inst %0d ov %b occ %0d data %h expected 0 0 not dead",
                                 c, i, ov_w[i], occ_w[i], data_w[i]);
                    end
                end
            end
            if (c == 3) begin
                checks++;
                if (occ_w[0] !== 4'd2) begin
                    errors++;
                    $display("FAIL flush_pre occ %0d expected 2", occ_w[0]);
                end
            end
            model_advance();
            @(posedge clk); #1;
        end
        flush = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] words [6];
        int k = 0;
        int cyc = 0;
        flush = 0; stall_clr = 0;
        for (int w = 0; w < 6; w++) words[w] = 32'h100 + 32'(w) * 32'h11;
        while ((k < 6 || mq[2].size() > 0) && cyc < 40) begin
            in_valid     = (k < 6);
            in_data      = (k < 6) ? words[k] : 32'h0;
            out_allow_in = cyc[0];
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL wrap cyc%0d inst %0d got %h expected %h", cyc, i, obs_vec(i), exp_vec(i));
                end
            end
            checks++;
            if (occ_w[2] > 4'd3) begin
                errors++;
                $display("FAIL wrap_occ cyc%0d occ %0d expected <=3", cyc, occ_w[2]);
            end
            if (in_valid && model_allow(2)) k++;
            model_advance();
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (k != 6 || cyc >= 40) begin
            errors++;
            $display("FAIL wrap_timeout pushed %0d cycles %0d expected 6 within 40", k, cyc);
        end
    endtask

    task automatic test_stall_sat();
        flush = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid     = (c == 0);
            in_data      = 32'h5A5A;
            out_allow_in = 0;
            stall_clr    = (c == 21);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL stall c%0d inst %0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
                end
            end
            if (c == 21 || c == 22 || c == 23) begin
                checks++;
                if (cnt_w[0] !== ((c == 21) ? 16'd15 : (c == 22) ? 16'd0 : 16'd1)) begin
                    errors++;
                    $display("FAIL stall_cnt c%0d got %0d expected %0d", c, cnt_w[0],
                             (c == 21) ? 15 : (c == 22) ? 0 : 1);
                end
            end
            model_advance();
            @(posedge clk); #1;
        end
        stall_clr = 0;
    endtask

    task automatic test_async_reset();
        flush = 0; stall_clr = 0; out_allow_in = 0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1;
            in_data  = 32'h7000 + 32'(c);
            @(negedge clk);
            model_advance();
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ov_w[i] !== 1'b0 || occ_w[i] !== 4'd0 || cnt_w[i] !== 16'd0) begin
                errors++;
                $display("FAIL async_reset inst %0d ov %b occ %0d cnt %0d expected 0 0 0",
                         i, ov_w[i], occ_w[i], cnt_w[i]);
            end
        end
        @(posedge clk);
        #3 reset = 1'b1;
        in_valid = 0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (allow_w[i] !== 1'b1 || ov_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release inst %0d allow %b ov %b expected 1 0", i, allow_w[i], ov_w[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_data      = $urandom;
            out_allow_in = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            stall_clr    = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random c%0d inst %0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
                end
            end
            model_advance();
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 0; stall_clr = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pass_through();
        test_flush();
        test_wrap();
        test_stall_sat();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
